jtag_scan_master: RTL and testbench
===================================

Name: jtag_scan_master

Overview:
- Host-side JTAG sequencer directly upstream of the s9234 JTAG top.
- Generates TMS/TDI to walk the TAP through complete IR or DR scans and captures TDO into a response word.
- Lets benches and the on-chip test controller issue "scan IR/DR, N bits" commands instead of hand-toggling TMS.
- All TAP-facing outputs are registered. The block runs on the same TCLK as the TAP controller it drives.

Parameters:
- MAXLEN, 32, maximum scan length in bits and width of the data/response words.
- LENW, 6, width of cmd_len; must be ≥ clog2(MAXLEN+1).
- RESET_CYCLES, 5, number of TMS=1 cycles in the reset walk to Test-Logic-Reset.

Ports:
- TCLK  input  1  clock; all state changes on the rising edge.
- TRST  input  1  reset; synchronous, active-high.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  master idle in Run-Test/Idle and able to accept a command.
- cmd_ir  input  1  1 = IR scan, 0 = DR scan.
- cmd_len  input  LENW  number of bits to shift, valid range 1..MAXLEN.
- cmd_data  input  MAXLEN  TDI bits, LSB shifted first.
- rsp_valid  output  1  one-cycle pulse; scan finished.
- rsp_data  output  MAXLEN  captured TDO bits, LSB = first captured.
- rsp_err  output  1  qualifies rsp_valid; illegal length.
- TMS  output  1  to TAP.
- TDI  output  1  to TAP.
- TDO  input  1  from TAP.

Behaviour:
- Reset values (while TRST=1 and on the following edge):
  - TMS=1, TDI=0, cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0.
  - State goes to RST_WALK with the counter cleared.
- RST_WALK:
  - Drives TMS=1 for RESET_CYCLES cycles, then TMS=0 for 1 cycle (TAP enters Run-Test/Idle).
  - Then moves to IDLE with cmd_ready=1.
- IDLE:
  - TMS=0, TDI=0; the TAP is held in Run-Test/Idle.
  - A command is accepted on an edge where cmd_valid & cmd_ready.
  - On acceptance: cmd_ir, cmd_len and cmd_data are latched; cmd_ready drops the next cycle.
- Length check:
  - If cmd_len==0 or cmd_len>MAXLEN there is no TAP activity (TMS stays 0).
  - rsp_valid=1 and rsp_err=1 the cycle after acceptance; rsp_data=0.
  - The master returns to IDLE.
- TMS/TDI sequence for a legal command (one value per cycle, starting the cycle after acceptance):
  - DR scan: TMS 1 (Select-DR), 0 (Capture-DR), 0 (enter Shift-DR).
  - IR scan: TMS 1, 1 (Select-IR), 0 (Capture-IR), 0 (enter Shift-IR).
  - SHIFT: cmd_len cycles. Cycle i drives TDI=data[i]. TMS=0 except on the last bit, where TMS=1 (Exit1).
  - UPDATE: TMS=1 (Update-xR), TDI=0.
  - RETURN: TMS=0 (Run-Test/Idle).
  - Total TAP cycles: DR = len+5, IR = len+6.
- TDO capture:
  - During shift cycle i, TDO is sampled on the edge that ends that cycle into rsp_data[i].
  - rsp_data bits ≥ cmd_len are 0.
- Response:
  - rsp_valid pulses for exactly 1 cycle, coincident with the RETURN cycle.
  - rsp_data and rsp_err hold until the next acceptance.
  - cmd_ready returns to 1 the cycle after the rsp_valid pulse.
- Accepted fields are stable internally; changes on cmd_* mid-scan have no effect.
- cmd_valid while cmd_ready=0 is ignored, not queued.
- Reset mid-scan:
  - Aborts immediately, with no rsp_valid for the aborted command.
  - Restarts RST_WALK, which always leaves the TAP in Test-Logic-Reset and then Run-Test/Idle regardless of prior TAP state.
- Bit counter width is LENW. A shift of MAXLEN bits must not wrap before the last bit.

Test Plan:
- Reset: TRST=1 for 2 cycles, then 0 → TMS=1 for exactly 5 cycles, then 0; cmd_ready=1 on the 7th cycle after reset release; TDI stays 0 throughout.
- IR scan: cmd_ir=1, len=2, data=2'b01 → TMS sequence 1,1,0,0,0,1,1,0; TDI during shift = 1,0. With the JTAG top attached, its IR holds 2'b01, the TAP returns to Run-Test/Idle, and rsp_valid pulses once.
- DR loopback: TDO tied to a 32-bit shift register fed by TDI, preloaded 32'hA5A5_0F0F; DR scan, len=32, data=32'hDEAD_BEEF → rsp_data=32'hA5A5_0F0F; the register then holds 32'hDEAD_BEEF; total 37 TAP cycles.
- Illegal lengths: len=0 and len=33 → rsp_valid=1 and rsp_err=1 one cycle after acceptance; TMS stays 0; rsp_data=0.
- Reset mid-scan: assert TRST at shift bit 10 of a len=20 DR scan → no rsp_valid; the 5×TMS=1 walk follows; a subsequent len=3 DR scan completes normally.
- Back-to-back: cmd_valid held high with two commands → the second is accepted only when cmd_ready reasserts, one cycle after the first rsp_valid; cmd_valid asserted mid-scan is ignored.

Source files
------------

// File: rtl/jtag_scan_master.sv
// Host-side JTAG sequencer: walks the TAP to Run-Test/Idle after reset, then runs
// complete IR/DR scans of 1..MAXLEN bits, driving TMS/TDI and capturing TDO.
module jtag_scan_master #(
  parameter int unsigned MAXLEN       = 32,
  parameter int unsigned LENW         = 6,
  parameter int unsigned RESET_CYCLES = 5
) (
  input  logic              TCLK,
  input  logic              TRST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_ir,
  input  logic [LENW-1:0]   cmd_len,
  input  logic [MAXLEN-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [MAXLEN-1:0] rsp_data,
  output logic              rsp_err,
  output logic              TMS,
  output logic              TDI,
  input  logic              TDO
);

  typedef enum logic [2:0] {
    RST_WALK,
    IDLE,
    PRE,
    SHIFT,
    UPDATE,
    DONE
  } state_t;

  localparam logic [LENW-1:0] RC_LAST = LENW'(RESET_CYCLES - 1);
  localparam logic [LENW-1:0] MAXLEN_L = LENW'(MAXLEN);

  state_t            state_q, state_d;
  logic [LENW-1:0]   cnt_q, cnt_d;
  logic [LENW-1:0]   len_q, len_d;
  logic              ir_q, ir_d;
  logic [MAXLEN-1:0] data_q, data_d;
  logic [MAXLEN-1:0] rsp_q, rsp_d;
  logic              ready_q, ready_d;
  logic              vld_q, vld_d;
  logic              err_q, err_d;
  logic              tms_q, tms_d;
  logic              tdi_q, tdi_d;

  logic              len_bad;
  logic [LENW-1:0]   pre_last;
  logic [LENW-1:0]   last_bit;

  assign len_bad  = (cmd_len == '0) || (cmd_len > MAXLEN_L);
  assign pre_last = ir_q ? LENW'(3) : LENW'(2);
  assign last_bit = len_q - LENW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ir_d    = ir_q;
    data_d  = data_q;
    rsp_d   = rsp_q;
    ready_d = ready_q;
    vld_d   = vld_q;
    err_d   = err_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;
    case (state_q)
      RST_WALK: begin
        tdi_d = 1'b0;
        if (cnt_q < RC_LAST) begin
          tms_d = 1'b1;
          cnt_d = cnt_q + LENW'(1);
        end else if (cnt_q == RC_LAST) begin
          tms_d = 1'b0;
          cnt_d = cnt_q + LENW'(1);
        end else begin
          tms_d   = 1'b0;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      IDLE: begin
        tms_d = 1'b0;
        tdi_d = 1'b0;
        if (cmd_valid && ready_q) begin
          ready_d = 1'b0;
          ir_d    = cmd_ir;
          len_d   = cmd_len;
          data_d  = cmd_data;
          rsp_d   = '0;
          cnt_d   = '0;
          if (len_bad) begin
            vld_d   = 1'b1;
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            tms_d   = 1'b1;
            state_d = PRE;
          end
        end
      end
      PRE: begin
        // Preamble position cnt_q is on the wire; only IR has a second TMS=1.
        if (cnt_q == pre_last) begin
          cnt_d   = '0;
          tdi_d   = data_q[0];
          tms_d   = (len_q == LENW'(1));
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + LENW'(1);
          tms_d = ir_q && (cnt_q == '0);
        end
      end
      SHIFT: begin
        // TDO enters at the top; UPDATE realigns so the first bit lands at bit 0.
        rsp_d = {TDO, rsp_q[MAXLEN-1:1]};
        if (cnt_q == last_bit) begin
          tms_d   = 1'b1;
          tdi_d   = 1'b0;
          state_d = UPDATE;
        end else begin
          cnt_d  = cnt_q + LENW'(1);
          data_d = data_q >> 1;
          tdi_d  = data_q[1];
          tms_d  = ((cnt_q + LENW'(1)) == last_bit);
        end
      end
      UPDATE: begin
        tms_d   = 1'b0;
        tdi_d   = 1'b0;
        vld_d   = 1'b1;
        rsp_d   = rsp_q >> (MAXLEN - 32'(len_q));
        state_d = DONE;
      end
      DONE: begin
        tms_d   = 1'b0;
        tdi_d   = 1'b0;
        vld_d   = 1'b0;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = RST_WALK;
    endcase
  end

  always_ff @(posedge TCLK) begin
    if (TRST) begin
      state_q <= RST_WALK;
      cnt_q   <= '0;
      len_q   <= '0;
      ir_q    <= 1'b0;
      data_q  <= '0;
      rsp_q   <= '0;
      ready_q <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ir_q    <= ir_d;
      data_q  <= data_d;
      rsp_q   <= rsp_d;
      ready_q <= ready_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
    end
  end

  assign cmd_ready = ready_q;
  assign rsp_valid = vld_q;
  assign rsp_data  = rsp_q;
  assign rsp_err   = err_q;
  assign TMS       = tms_q;
  assign TDI       = tdi_q;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: a behavioural TAP with 2-bit IR and 32-bit loopback DR
// sits on TMS/TDI/TDO; table vectors plus reset, abort and back-to-back sequences.
module tb_jtag_scan_master;
  localparam int unsigned MAXLEN = 32;
  localparam int unsigned LENW   = 6;

  logic              TCLK = 1'b0;
  logic              TRST = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_ir = 1'b0;
  logic [LENW-1:0]   cmd_len = '0;
  logic [MAXLEN-1:0] cmd_data = '0;
  logic              rsp_valid;
  logic [MAXLEN-1:0] rsp_data;
  logic              rsp_err;
  logic              TMS;
  logic              TDI;
  logic              TDO;

  int checks = 0;
  int errors = 0;

  always #5 TCLK = ~TCLK;

  jtag_scan_master #(
    .MAXLEN      (MAXLEN),
    .LENW        (LENW),
    .RESET_CYCLES(5)
  ) dut (
    .TCLK     (TCLK),
    .TRST     (TRST),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_ir   (cmd_ir),
    .cmd_len  (cmd_len),
    .cmd_data (cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .TMS      (TMS),
    .TDI      (TDI),
    .TDO      (TDO)
  );

  // Behavioural TAP controller, started in an arbitrary state.
  typedef enum int {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
                    SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR} tap_t;
  tap_t        tap = EX2DR;
  logic [31:0] dr = '0;
  logic [31:0] ld_val = '0;
  logic        ld = 1'b0;
  logic [1:0]  ir = '0;
  logic [1:0]  ir_sr = '0;

  function automatic tap_t tap_next(input tap_t s, input logic t);
    case (s)
      TLR:     return t ? TLR   : RTI;
      RTI:     return t ? SELDR : RTI;
      SELDR:   return t ? SELIR : CAPDR;
      CAPDR:   return t ? EX1DR : SHDR;
      SHDR:    return t ? EX1DR : SHDR;
      EX1DR:   return t ? UPDR  : PADR;
      PADR:    return t ? EX2DR : PADR;
      EX2DR:   return t ? UPDR  : SHDR;
      UPDR:    return t ? SELDR : RTI;
      SELIR:   return t ? TLR   : CAPIR;
      CAPIR:   return t ? EX1IR : SHIR;
      SHIR:    return t ? EX1IR : SHIR;
      EX1IR:   return t ? UPIR  : PAIR;
      PAIR:    return t ? EX2IR : PAIR;
      EX2IR:   return t ? UPIR  : SHIR;
      default: return t ? SELDR : RTI;
    endcase
  endfunction

  assign TDO = (tap == SHDR) ? dr[0] : (tap == SHIR) ? ir_sr[0] : 1'b0;

  always @(posedge TCLK) begin
    if (tap == SHDR)      dr <= {TDI, dr[31:1]};
    else if (ld)          dr <= ld_val;
    if (tap == CAPIR)     ir_sr <= 2'b01;
    else if (tap == SHIR) ir_sr <= {TDI, ir_sr[1]};
    if (tap == UPIR)      ir <= ir_sr;
    tap <= tap_next(tap, TMS);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] v);
    @(negedge TCLK);
    ld_val = v;
    ld     = 1'b1;
    @(negedge TCLK);
    ld     = 1'b0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 200 && !cmd_ready; i++) @(negedge TCLK);
    chk("ready_timeout", 64'(cmd_ready), 64'd1);
  endtask

  // Returns on the negedge of the first cycle after acceptance; the cmd_*
  // fields are scrambled so the latched copy is what must be used.
  task automatic issue(input logic i_ir, input logic [LENW-1:0] i_len, input logic [31:0] i_data);
    wait_ready();
    cmd_ir    = i_ir;
    cmd_len   = i_len;
    cmd_data  = i_data;
    cmd_valid = 1'b1;
    @(negedge TCLK);
    cmd_valid = 1'b0;
    cmd_ir    = ~i_ir;
    cmd_len   = ~i_len;
    cmd_data  = ~i_data;
  endtask

  // Counts cycles from acceptance up to and including the rsp_valid cycle,
  // recording TMS MSB-first.
  task automatic collect(output int lat, output logic [63:0] seq);
    lat = 0;
    seq = '0;
    for (int i = 0; i < 100; i++) begin
      lat++;
      seq = {seq[62:0], TMS};
      if (rsp_valid) break;
      @(negedge TCLK);
    end
  endtask

  // Entered on the negedge after the TRST edge, with TRST still high.
  task automatic walk(input string tag);
    logic seen = 1'b0;
    chk({tag, "_rst_tms"},  64'(TMS), 64'd1);
    chk({tag, "_rst_tdi"},  64'(TDI), 64'd0);
    chk({tag, "_rst_rdy"},  64'(cmd_ready), 64'd0);
    chk({tag, "_rst_vld"},  64'(rsp_valid), 64'd0);
    chk({tag, "_rst_err"},  64'(rsp_err), 64'd0);
    chk({tag, "_rst_data"}, 64'(rsp_data), 64'd0);
    TRST = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      chk($sformatf("%s_walk_tms%0d", tag, k), 64'(TMS), 64'(k <= 5));
      chk($sformatf("%s_walk_rdy%0d", tag, k), 64'(cmd_ready), 64'(k == 7));
      seen = seen | rsp_valid | TDI;
      if (k < 7) @(negedge TCLK);
    end
    chk({tag, "_walk_quiet"}, 64'(seen), 64'd0);
    chk({tag, "_walk_tap"},   64'(tap == RTI), 64'd1);
  endtask

  typedef struct {
    logic            ir;
    logic [LENW-1:0] len;
    logic [31:0]     data;
    logic [31:0]     pre;
    logic [31:0]     rsp;
    logic            err;
    int              lat;
    logic [63:0]     seq;
    logic [31:0]     reg_after;
  } vec_t;

  vec_t tv[7];

  initial begin
    int          lat;
    logic [63:0] seq;
    logic        seen;

    //        ir    len    data           pre            rsp            err   lat seq                 reg_after
    tv[0] = '{1'b1, 6'd2,  32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 1'b0, 8,  64'hC6,             32'h0000_0001};
    tv[1] = '{1'b0, 6'd32, 32'hDEAD_BEEF, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 1'b0, 37, 64'h10_0000_0006,   32'hDEAD_BEEF};
    tv[2] = '{1'b0, 6'd8,  32'h0000_003C, 32'h1234_5678, 32'h0000_0078, 1'b0, 13, 64'h1006,           32'h3C12_3456};
    tv[3] = '{1'b0, 6'd1,  32'h0000_0001, 32'h0000_0003, 32'h0000_0001, 1'b0, 6,  64'h26,             32'h8000_0001};
    tv[4] = '{1'b0, 6'd0,  32'hFFFF_FFFF, 32'h1111_1111, 32'h0000_0000, 1'b1, 1,  64'h0,              32'h1111_1111};
    tv[5] = '{1'b0, 6'd33, 32'hFFFF_FFFF, 32'h2222_2222, 32'h0000_0000, 1'b1, 1,  64'h0,              32'h2222_2222};
    tv[6] = '{1'b1, 6'd2,  32'h0000_0002, 32'h0000_0000, 32'h0000_0001, 1'b0, 8,  64'hC6,             32'h0000_0002};

    repeat (2) @(posedge TCLK);
    @(negedge TCLK);
    walk("init");

    for (int v = 0; v < 7; v++) begin
      preload(tv[v].pre);
      issue(tv[v].ir, tv[v].len, tv[v].data);
      collect(lat, seq);
      chk($sformatf("v%0d_lat", v),  64'(lat), 64'(tv[v].lat));
      chk($sformatf("v%0d_tms", v),  seq, tv[v].seq);
      chk($sformatf("v%0d_rsp", v),  64'(rsp_data), 64'(tv[v].rsp));
      chk($sformatf("v%0d_err", v),  64'(rsp_err), 64'(tv[v].err));
      @(negedge TCLK);
      chk($sformatf("v%0d_pulse", v), 64'(rsp_valid), 64'd0);
      chk($sformatf("v%0d_ready", v), 64'(cmd_ready), 64'd1);
      chk($sformatf("v%0d_tap", v),   64'(tap == RTI), 64'd1);
      chk($sformatf("v%0d_hold", v),  64'({rsp_err, rsp_data}), 64'({tv[v].err, tv[v].rsp}));
      chk($sformatf("v%0d_reg", v),   64'(tv[v].ir ? {30'd0, ir} : dr), 64'(tv[v].reg_after));
    end

    // Abort at shift bit 10 of a 20-bit DR scan.
    preload(32'hFFFF_FFFF);
    issue(1'b0, 6'd20, 32'h000F_FFFF);
    seen = rsp_valid;
    for (int i = 0; i < 13; i++) begin
      @(negedge TCLK);
      seen = seen | rsp_valid;
    end
    chk("abort_in_shift", 64'(tap == SHDR), 64'd1);
    TRST = 1'b1;
    @(negedge TCLK);
    walk("abort");
    chk("abort_no_rsp", 64'(seen), 64'd0);
    preload(32'h0000_0006);
    issue(1'b0, 6'd3, 32'h0000_0005);
    collect(lat, seq);
    chk("post_abort_lat", 64'(lat), 64'd8);
    chk("post_abort_tms", seq, 64'h86);
    chk("post_abort_rsp", 64'(rsp_data), 64'h6);
    @(negedge TCLK);
    chk("post_abort_dr",  64'(dr), 64'hA000_0000);

    // Back-to-back with cmd_valid held high; the second command is presented mid-scan.
    preload(32'h0000_0005);
    wait_ready();
    cmd_ir    = 1'b0;
    cmd_len   = 6'd4;
    cmd_data  = 32'h0000_000A;
    cmd_valid = 1'b1;
    @(negedge TCLK);
    cmd_len   = 6'd32;
    cmd_data  = 32'h0000_0000;
    collect(lat, seq);
    chk("b2b_a_lat", 64'(lat), 64'd9);
    chk("b2b_a_rsp", 64'(rsp_data), 64'h5);
    @(negedge TCLK);
    chk("b2b_a_ready", 64'(cmd_ready), 64'd1);
    chk("b2b_a_dr",    64'(dr), 64'hA000_0000);
    @(negedge TCLK);
    cmd_valid = 1'b0;
    chk("b2b_b_taken", 64'(cmd_ready), 64'd0);
    collect(lat, seq);
    chk("b2b_b_lat", 64'(lat), 64'd37);
    chk("b2b_b_rsp", 64'(rsp_data), 64'hA000_0000);
    @(negedge TCLK);
    chk("b2b_b_dr",  64'(dr), 64'h0);
    chk("b2b_idle",  64'(cmd_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
